pu_rd_req_arbiter: RTL and testbench
====================================

# pu_rd_req_arbiter

Shares the single memory read-request channel (`rd_req`, `rd_req_size`, `rd_req_pu_id`, `rd_req_d_type`) between NUM_PU processing units. Each PU raises a request with size and data type. The arbiter grants one PU at a time, round-robin, and issues the request downstream to the buffer read counter and memory interface. The number of in-flight reads is bounded by a credit counter, which is returned on `rd_done`.

## Interface
- NUM_PU, 4: number of requesting PUs (≥1).
- D_TYPE_W, 2: data-type field width.
- RD_SIZE_W, 20: read-size field width.
- PU_ID_W, `C_LOG_2(NUM_PU)+1: PU id width.
- MAX_OUTSTANDING, 4: maximum issued-but-not-done reads (1..15).
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- pu_rd_req  in  NUM_PU  per-PU request level; held until acked.
- pu_rd_req_size  in  NUM_PU*RD_SIZE_W  per-PU size; PU i occupies bits [i*RD_SIZE_W +: RD_SIZE_W].
- pu_rd_req_d_type  in  NUM_PU*D_TYPE_W  per-PU data type, packed the same way.
- pu_rd_ack  out  NUM_PU  one-hot, one-cycle pulse; the request has been latched.
- rd_req  out  1  downstream request valid.
- rd_req_ready  in  1  downstream accept.
- rd_req_size  out  RD_SIZE_W  latched size.
- rd_req_pu_id  out  PU_ID_W  granted PU index.
- rd_req_d_type  out  D_TYPE_W  latched type.
- rd_done  in  1  one pulse per completed read; returns one credit.
- outstanding  out  4  current in-flight count.
- stall_cycles  out  32  backpressure counter (see Configuration).

## Operation
- FSM states: IDLE, GRANT, ISSUE.
- IDLE → GRANT when |pu_rd_req and outstanding < MAX_OUTSTANDING.
- GRANT (1 cycle):
  - Select the first requesting PU at or after rr_ptr, wrapping modulo NUM_PU.
  - Latch its size, type and index into the output registers.
  - Pulse pu_rd_ack[idx].
  - Set rr_ptr = idx+1, wrapping NUM_PU-1 → 0.
  - Go to ISSUE.
- ISSUE: rd_req = 1; outputs stay stable. On rd_req_ready → IDLE.
- Credit counter:
  - +1 on (rd_req & rd_req_ready).
  - −1 on rd_done.
  - Both in the same cycle → unchanged.
  - rd_done at outstanding==0 is ignored; the counter saturates at 0.
- Eligibility is evaluated in IDLE with the registered outstanding value, so the counter never exceeds MAX_OUTSTANDING.
- A PU must drop pu_rd_req the cycle after its ack, or it re-arbitrates as a new request.
- Requests that deassert before a grant are dropped silently.
- NUM_PU==1: rr_ptr is constant 0.

## Timing
- Reset values:
  - State IDLE, rr_ptr 0.
  - pu_rd_ack 0, rd_req 0.
  - rd_req_size, rd_req_pu_id, rd_req_d_type 0.
  - outstanding 0, stall_cycles 0.
- Latency: request seen in IDLE at cycle T → ack at T+1 → rd_req at T+2.
- Minimum spacing between issued requests is 3 cycles (IDLE, GRANT, ISSUE with immediate ready).
- Reset mid-operation: all state clears immediately. In-flight credits are forgotten, and downstream must be reset together.
- rd_req_ready while not in ISSUE is ignored.

## Configuration
- `PU_RD_ARB_STATS_EN` defined:
  - stall_cycles increments every cycle with rd_req & ~rd_req_ready.
  - It saturates at 2^32−1.
- Not defined: stall_cycles is tied to 0 and no counter logic is built.

## Structure
- Shared package `pu_rd_arb_pkg`:
  - FSM state typedef (IDLE=0, GRANT=1, ISSUE=2, 2-bit).
  - OUTSTANDING_W=4 constant.
- One sub-module: `rr_priority_select`.
  - Combinational NUM_PU-wide rotate/priority encode.
  - Inputs: request vector and rr_ptr.
  - Outputs: one-hot grant and binary index.

## Test plan
- Single request: NUM_PU=4, PU2 requests size 0x100 type 1, ready always 1. Expected: ack[2] at T+1; rd_req at T+2 with size 0x100, pu_id 2, d_type 1; outstanding=1.
- Round-robin: PU0..3 requesting continuously (each re-raises after ack), rr_ptr=0. Expected: grant order 0,1,2,3,0, with no PU granted twice before the others.
- Credit limit: MAX_OUTSTANDING=4, no rd_done, 6 requests. Expected: exactly 4 issued; the FSM stays in IDLE with outstanding=4. One rd_done → 5th issued 3 cycles later.
- Simultaneous events: rd_req&rd_req_ready and rd_done in the same cycle at outstanding=2. Expected: stays 2. rd_done at 0 → stays 0.
- Backpressure: rd_req_ready low for 7 cycles in ISSUE. Expected:
  - rd_req and fields stable throughout.
  - stall_cycles=7 with PU_RD_ARB_STATS_EN, 0 without.
- Async reset asserted during ISSUE. Expected: rd_req and outstanding go to 0 without waiting for a clock edge; the next grant starts from PU0.

Source files
------------

// File: rtl/pu_rd_req_arbiter_pkg.sv
// Shared types and constants for the PU read-request arbiter.
package pu_rd_arb_pkg;

  // Width of the in-flight read counter; it can hold up to 15.
  localparam int OUTSTANDING_W = 4;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ISSUE = 2'd2
  } arb_state_e;

  // 32-bit increment that holds at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : (value + 32'd1);
  endfunction

endpackage

// File: rtl/pu_rd_req_arbiter_if.sv
// Bundle of the PU request side and the downstream read-request channel.
// master: the arbiter; slave: the PUs plus the downstream consumer.
interface pu_rd_req_arbiter_if #(
  parameter int NUM_PU    = 4,
  parameter int D_TYPE_W  = 2,
  parameter int RD_SIZE_W = 20,
  parameter int PU_ID_W   = $clog2(NUM_PU) + 1
);

  logic [NUM_PU-1:0]           pu_rd_req;
  logic [NUM_PU*RD_SIZE_W-1:0] pu_rd_req_size;
  logic [NUM_PU*D_TYPE_W-1:0]  pu_rd_req_d_type;
  logic [NUM_PU-1:0]           pu_rd_ack;
  logic                        rd_req;
  logic                        rd_req_ready;
  logic [RD_SIZE_W-1:0]        rd_req_size;
  logic [PU_ID_W-1:0]          rd_req_pu_id;
  logic [D_TYPE_W-1:0]         rd_req_d_type;
  logic                        rd_done;

  modport master (
    input  pu_rd_req, pu_rd_req_size, pu_rd_req_d_type, rd_req_ready, rd_done,
    output pu_rd_ack, rd_req, rd_req_size, rd_req_pu_id, rd_req_d_type
  );

  modport slave (
    output pu_rd_req, pu_rd_req_size, pu_rd_req_d_type, rd_req_ready, rd_done,
    input  pu_rd_ack, rd_req, rd_req_size, rd_req_pu_id, rd_req_d_type
  );

endinterface

// File: rtl/pu_rd_req_arbiter_rr_priority_select.sv
// Round-robin priority select: first set request at or after rr_ptr,
// wrapping modulo NUM_PU. Purely combinational.
module rr_priority_select
  import pu_rd_arb_pkg::*;
#(
  parameter int NUM_PU = 4,
  parameter int PTR_W  = 2,
  parameter int IDX_W  = 3
) (
  input  logic [NUM_PU-1:0] req,
  input  logic [PTR_W-1:0]  rr_ptr,
  output logic [NUM_PU-1:0] grant,
  output logic [IDX_W-1:0]  idx,
  output logic              valid
);

  logic [PTR_W-1:0] pos_s;
  logic             hit_s;

  // Walk the request vector starting at rr_ptr and keep the first hit.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    pos_s = '0;
    hit_s = 1'b0;
    for (int k = 0; k < NUM_PU; k++) begin
      pos_s        = PTR_W'((int'(rr_ptr) + k) % NUM_PU);
      hit_s        = !valid && req[pos_s];
      grant[pos_s] = grant[pos_s] | hit_s;
      idx          = hit_s ? IDX_W'(pos_s) : idx;
      valid        = valid | hit_s;
    end
  end

endmodule

// File: rtl/pu_rd_req_arbiter.sv
// Round-robin arbiter sharing one memory read-request channel between
// NUM_PU processing units, with a credit limit on in-flight reads.
// Optional build macro PU_RD_ARB_STATS_EN adds a saturating backpressure
// counter on stall_cycles; without it stall_cycles is constant zero.
module pu_rd_req_arbiter
  import pu_rd_arb_pkg::*;
#(
  parameter int NUM_PU          = 4,
  parameter int D_TYPE_W        = 2,
  parameter int RD_SIZE_W       = 20,
  parameter int PU_ID_W         = $clog2(NUM_PU) + 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  pu_rd_req_arbiter_if.master      bus,
  output logic [OUTSTANDING_W-1:0] outstanding,
  output logic [31:0]              stall_cycles
);

  // Pointer width; a single PU still gets a 1-bit pointer held at zero.
  localparam int PTR_W = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;

  arb_state_e               state_r;
  logic [PTR_W-1:0]         rr_ptr_r;
  logic [NUM_PU-1:0]        pu_rd_ack_r;
  logic                     rd_req_r;
  logic [RD_SIZE_W-1:0]     rd_req_size_r;
  logic [PU_ID_W-1:0]       rd_req_pu_id_r;
  logic [D_TYPE_W-1:0]      rd_req_d_type_r;
  logic [OUTSTANDING_W-1:0] outstanding_r;

  logic [NUM_PU-1:0]        grant_s;
  logic [PU_ID_W-1:0]       grant_idx_s;
  logic                     grant_valid_s;
  logic [RD_SIZE_W-1:0]     sel_size_s;
  logic [D_TYPE_W-1:0]      sel_d_type_s;
  logic [PTR_W-1:0]         next_ptr_s;
  logic                     eligible_s;
  logic                     credit_inc_s;
  logic                     credit_dec_s;

  rr_priority_select #(
    .NUM_PU (NUM_PU),
    .PTR_W  (PTR_W),
    .IDX_W  (PU_ID_W)
  ) u_rr_sel (
    .req    (bus.pu_rd_req),
    .rr_ptr (rr_ptr_r),
    .grant  (grant_s),
    .idx    (grant_idx_s),
    .valid  (grant_valid_s)
  );

  // Mux the winning PU's size and type out of the packed request buses.
  always_comb begin
    sel_size_s   = '0;
    sel_d_type_s = '0;
    for (int i = 0; i < NUM_PU; i++) begin
      sel_size_s   = sel_size_s
                   | ({RD_SIZE_W{grant_s[i]}} & bus.pu_rd_req_size[i*RD_SIZE_W +: RD_SIZE_W]);
      sel_d_type_s = sel_d_type_s
                   | ({D_TYPE_W{grant_s[i]}} & bus.pu_rd_req_d_type[i*D_TYPE_W +: D_TYPE_W]);
    end
  end

  // Pointer moves just past the winner, wrapping the last PU back to 0.
  always_comb begin
    if (grant_idx_s == PU_ID_W'(NUM_PU - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = PTR_W'(grant_idx_s + PU_ID_W'(1));
    end
  end

  // A grant may start only with a pending request and a free credit
  // judged on the registered count, so the count can never overshoot.
  assign eligible_s   = grant_valid_s
                      && (outstanding_r < OUTSTANDING_W'(MAX_OUTSTANDING));
  assign credit_inc_s = rd_req_r && bus.rd_req_ready;
  assign credit_dec_s = bus.rd_done && (outstanding_r != '0);

  // Arbitration FSM; the winner is captured on the IDLE->GRANT edge so the
  // registered ack is visible during GRANT and rd_req rises one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r         <= IDLE;
      rr_ptr_r        <= '0;
      pu_rd_ack_r     <= '0;
      rd_req_r        <= 1'b0;
      rd_req_size_r   <= '0;
      rd_req_pu_id_r  <= '0;
      rd_req_d_type_r <= '0;
    end else begin
      pu_rd_ack_r <= '0;
      case (state_r)
        IDLE: begin
          if (eligible_s) begin
            pu_rd_ack_r     <= grant_s;
            rd_req_size_r   <= sel_size_s;
            rd_req_d_type_r <= sel_d_type_s;
            rd_req_pu_id_r  <= grant_idx_s;
            rr_ptr_r        <= next_ptr_s;
            state_r         <= GRANT;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT: begin
          rd_req_r <= 1'b1;
          state_r  <= ISSUE;
        end
        ISSUE: begin
          if (bus.rd_req_ready) begin
            rd_req_r <= 1'b0;
            state_r  <= IDLE;
          end else begin
            state_r <= ISSUE;
          end
        end
        default: begin
          rd_req_r <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  // Credit counter: +1 per accepted request, -1 per completion, both cancel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding_r <= '0;
    end else begin
      case ({credit_inc_s, credit_dec_s})
        2'b10:   outstanding_r <= outstanding_r + OUTSTANDING_W'(1);
        2'b01:   outstanding_r <= outstanding_r - OUTSTANDING_W'(1);
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

`ifdef PU_RD_ARB_STATS_EN
  logic [31:0] stall_cycles_r;

  // Count cycles where a request is presented but not accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_r <= 32'd0;
    end else if (rd_req_r && !bus.rd_req_ready) begin
      stall_cycles_r <= sat_inc32(stall_cycles_r);
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  assign stall_cycles = stall_cycles_r;
`else
  assign stall_cycles = 32'd0;
`endif

  assign bus.pu_rd_ack     = pu_rd_ack_r;
  assign bus.rd_req        = rd_req_r;
  assign bus.rd_req_size   = rd_req_size_r;
  assign bus.rd_req_pu_id  = rd_req_pu_id_r;
  assign bus.rd_req_d_type = rd_req_d_type_r;
  assign outstanding       = outstanding_r;

endmodule

// File: tb/tb_pu_rd_req_arbiter.sv
// Directed self-checking bench for pu_rd_req_arbiter (NUM_PU=4,
// MAX_OUTSTANDING=4). Inputs change and outputs are sampled on negedge.
module tb_pu_rd_req_arbiter;

  localparam int NUM_PU    = 4;
  localparam int D_TYPE_W  = 2;
  localparam int RD_SIZE_W = 20;
  localparam int PU_ID_W   = 3;

`ifdef PU_RD_ARB_STATS_EN
  localparam logic [31:0] EXP_STALL = 32'd7;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  logic        clk;
  logic        reset;
  logic [3:0]  outstanding;
  logic [31:0] stall_cycles;
  int          n_checks = 0;
  int          n_errors = 0;
  int          idx;
  int          count;
  int          stable_err;

  pu_rd_req_arbiter_if #(
    .NUM_PU(NUM_PU), .D_TYPE_W(D_TYPE_W), .RD_SIZE_W(RD_SIZE_W), .PU_ID_W(PU_ID_W)
  ) bus ();

  pu_rd_req_arbiter #(
    .NUM_PU(NUM_PU), .D_TYPE_W(D_TYPE_W), .RD_SIZE_W(RD_SIZE_W),
    .PU_ID_W(PU_ID_W), .MAX_OUTSTANDING(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .outstanding  (outstanding),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input int pu, input logic [RD_SIZE_W-1:0] size,
                         input logic [D_TYPE_W-1:0] dt);
    bus.pu_rd_req[pu] = 1'b1;
    bus.pu_rd_req_size[pu*RD_SIZE_W +: RD_SIZE_W] = size;
    bus.pu_rd_req_d_type[pu*D_TYPE_W +: D_TYPE_W] = dt;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic wait_ack(output int found);
    found = -1;
    for (int c = 0; c < 20 && found < 0; c++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_PU; i++) begin
        if (bus.pu_rd_ack[i]) found = i;
      end
    end
    check("ack_seen", (found >= 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    bus.pu_rd_req = '0;
    bus.pu_rd_req_size = '0;
    bus.pu_rd_req_d_type = '0;
    bus.rd_req_ready = 1'b0;
    bus.rd_done = 1'b0;
    tick(3);

    // reset values
    check("rst_rd_req", 32'(bus.rd_req), 32'd0);
    check("rst_ack", 32'(bus.pu_rd_ack), 32'd0);
    check("rst_outstanding", 32'(outstanding), 32'd0);
    check("rst_stall", stall_cycles, 32'd0);
    check("rst_size", 32'(bus.rd_req_size), 32'd0);
    check("rst_pu_id", 32'(bus.rd_req_pu_id), 32'd0);
    check("rst_d_type", 32'(bus.rd_req_d_type), 32'd0);
    reset = 1'b0;
    bus.rd_req_ready = 1'b1;
    tick(1);

    // single request from PU2
    set_req(2, 20'h100, 2'd1);
    tick(1);
    check("single_ack", 32'(bus.pu_rd_ack), 32'h4);
    check("single_no_req_yet", 32'(bus.rd_req), 32'd0);
    bus.pu_rd_req = '0;
    tick(1);
    check("single_rd_req", 32'(bus.rd_req), 32'd1);
    check("single_size", 32'(bus.rd_req_size), 32'h100);
    check("single_pu_id", 32'(bus.rd_req_pu_id), 32'd2);
    check("single_d_type", 32'(bus.rd_req_d_type), 32'd1);
    tick(1);
    check("single_rd_req_drop", 32'(bus.rd_req), 32'd0);
    check("single_outstanding", 32'(outstanding), 32'd1);
    bus.rd_done = 1'b1;
    tick(1);
    bus.rd_done = 1'b0;
    check("single_done", 32'(outstanding), 32'd0);

    // round robin: all four request continuously, pointer starts at 0
    pulse_reset();
    for (int p = 0; p < NUM_PU; p++) set_req(p, RD_SIZE_W'(20'h10 + p), 2'(p));
    for (int g = 0; g < 5; g++) begin
      wait_ack(idx);
      check("rr_grant", 32'(idx), 32'(g % NUM_PU));
      tick(1);
      check("rr_pu_id", 32'(bus.rd_req_pu_id), 32'(g % NUM_PU));
      check("rr_size", 32'(bus.rd_req_size), 32'h10 + 32'(g % NUM_PU));
      bus.rd_done = 1'b1;
      tick(1);
      bus.rd_done = 1'b0;
      check("rr_outstanding", 32'(outstanding), 32'd1);
    end
    bus.pu_rd_req = '0;

    // credit limit: PU1 keeps requesting, no completions
    pulse_reset();
    set_req(1, 20'h55, 2'd3);
    count = 0;
    for (int c = 0; c < 40; c++) begin
      tick(1);
      if (bus.rd_req) count++;
    end
    check("credit_issued", 32'(count), 32'd4);
    check("credit_outstanding", 32'(outstanding), 32'd4);
    check("credit_idle", 32'(bus.rd_req), 32'd0);
    bus.rd_done = 1'b1;
    tick(1);
    bus.rd_done = 1'b0;
    check("credit_after_done", 32'(outstanding), 32'd3);
    tick(1);
    check("credit_ack5", 32'(bus.pu_rd_ack), 32'h2);
    bus.pu_rd_req = '0;
    tick(1);
    check("credit_req5", 32'(bus.rd_req), 32'd1);
    tick(1);
    check("credit_full_again", 32'(outstanding), 32'd4);

    // simultaneous accept and completion at outstanding 2
    bus.rd_done = 1'b1;
    tick(2);
    bus.rd_done = 1'b0;
    check("sim_pre", 32'(outstanding), 32'd2);
    set_req(3, 20'hABC, 2'd2);
    tick(1);
    check("sim_ack", 32'(bus.pu_rd_ack), 32'h8);
    bus.pu_rd_req = '0;
    tick(1);
    check("sim_rd_req", 32'(bus.rd_req), 32'd1);
    bus.rd_done = 1'b1;
    tick(1);
    bus.rd_done = 1'b0;
    check("sim_both", 32'(outstanding), 32'd2);
    bus.rd_done = 1'b1;
    tick(2);
    check("sim_drain", 32'(outstanding), 32'd0);
    tick(1);
    bus.rd_done = 1'b0;
    check("done_at_zero", 32'(outstanding), 32'd0);

    // backpressure: ready low for 7 cycles while issuing
    bus.rd_req_ready = 1'b0;
    set_req(0, 20'h3A5, 2'd2);
    tick(1);
    check("bp_ack", 32'(bus.pu_rd_ack), 32'h1);
    bus.pu_rd_req = '0;
    tick(1);
    stable_err = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.rd_req !== 1'b1 || bus.rd_req_size !== 20'h3A5 ||
          bus.rd_req_pu_id !== 3'd0 || bus.rd_req_d_type !== 2'd2) stable_err++;
      if (c < 7) tick(1);
    end
    check("bp_stable", 32'(stable_err), 32'd0);
    check("bp_stall", stall_cycles, EXP_STALL);
    bus.rd_req_ready = 1'b1;
    tick(1);
    check("bp_release", 32'(bus.rd_req), 32'd0);
    check("bp_outstanding", 32'(outstanding), 32'd1);
    check("bp_stall_hold", stall_cycles, EXP_STALL);

    // async reset in ISSUE after a PU1 grant (pointer now at 2)
    bus.rd_req_ready = 1'b0;
    set_req(1, 20'h77, 2'd1);
    tick(1);
    check("ar_ack", 32'(bus.pu_rd_ack), 32'h2);
    bus.pu_rd_req = '0;
    tick(1);
    check("ar_rd_req", 32'(bus.rd_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("ar_rd_req_clr", 32'(bus.rd_req), 32'd0);
    check("ar_outstanding_clr", 32'(outstanding), 32'd0);
    check("ar_stall_clr", stall_cycles, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.rd_req_ready = 1'b1;
    for (int p = 0; p < NUM_PU; p++) set_req(p, RD_SIZE_W'(20'h200 + p), 2'd0);
    tick(1);
    check("ar_grant_pu0", 32'(bus.pu_rd_ack), 32'h1);
    bus.pu_rd_req = '0;
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
